// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions used by uart_rx and uart_tx.
//   FSM state encodings (IDLE/START/DATA/STOP) and bit-timing helpers.
package uart_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return (clk_hz - 1) / bit_rate;
  endfunction
  function automatic int half_bit(input int clk_hz, input int bit_rate);
    return cycles_per_bit(clk_hz, bit_rate) / 2;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for an asynchronous input.
//   clk    in  system clock
//   resetn in  asynchronous active-low reset
//   d      in  asynchronous input
//   q      out synchronised output (second flop), resets to RST_VAL
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q, ff_d;
  always_comb ff_d = {ff_q[0], d};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) ff_q <= {2{RST_VAL}};
    else         ff_q <= ff_d;
  assign q = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with holding register, valid/read handshake and sticky error flags.
//   clk               in  system clock
//   resetn            in  asynchronous active-low reset
//   uart_rxd          in  receive pin, async, idles high
//   uart_rx_read      in  one-cycle pulse: consume byte, clear flags
//   uart_rx_data      out last accepted byte
//   uart_rx_valid     out holding register holds an unread byte
//   uart_rx_busy      out frame in progress
//   uart_rx_overrun   out sticky: byte dropped while valid was set
//   uart_rx_frame_err out sticky: stop bit sampled low
// Build option: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around each bit centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_read,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_busy,
  output logic                    uart_rx_overrun,
  output logic                    uart_rx_frame_err
);
  localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int HB  = half_bit(CLK_HZ, BIT_RATE);
  localparam int CW  = 1 + $clog2(CPB);
  localparam int BW  = $clog2(PAYLOAD_BITS + 1);
  if (STOP_BITS < 1) begin : g_bad_stop
    $error("uart_rx: STOP_BITS must be at least 1");
  end
  logic rxd_s, sample;
  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (uart_rxd),
    .q      (rxd_s)
  );
`ifdef UART_RX_MAJORITY_EN
  // Decision is taken one cycle after the nominal point, so the start
  // threshold moves by one and every later bit follows automatically.
  localparam int START_AT = HB + 1;
  logic [1:0] hist_q, hist_d;
  always_comb hist_d = {hist_q[0], rxd_s};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) hist_q <= 2'b11;
    else         hist_q <= hist_d;
  assign sample = (rxd_s & hist_q[0]) | (rxd_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  localparam int START_AT = HB;
  assign sample = rxd_s;
`endif
  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PAYLOAD_BITS:0]   shift_in;
  logic                    last_q, last_d;
  logic                    accept_q, accept_d;
  logic                    ferr_set;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    frame_err_q, frame_err_d;
  assign shift_in = {sample, shift_q};
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    last_d   = rxd_s;
    accept_d = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Start only on a falling edge: a held-low line (break) must rise first.
        if (!rxd_s && last_q) state_d = START;
      end
      START: if (cnt_q == CW'(START_AT)) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = sample ? IDLE : DATA;
      end
      DATA: if (cnt_q == CW'(CPB)) begin
        cnt_d   = '0;
        shift_d = shift_in[PAYLOAD_BITS:1];
        idx_d   = idx_q + BW'(1);
        if (idx_q == BW'(PAYLOAD_BITS - 1)) state_d = STOP;
      end
      default: if (cnt_q == CW'(CPB)) begin
        cnt_d    = '0;
        state_d  = IDLE;
        accept_d = sample;
        ferr_set = !sample;
      end
    endcase
  end
  // Holding register: a read in the accept cycle frees room for the new byte.
  always_comb begin
    data_d      = (accept_q && (!valid_q || uart_rx_read)) ? shift_q : data_q;
    valid_d     = accept_q | (valid_q & ~uart_rx_read);
    overrun_d   = (accept_q & valid_q & ~uart_rx_read) | (overrun_q & ~uart_rx_read);
    frame_err_d = ferr_set | (frame_err_q & ~uart_rx_read);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      last_q      <= 1'b1;
      accept_q    <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      accept_q    <= accept_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  assign uart_rx_data      = data_q;
  assign uart_rx_valid     = valid_q;
  assign uart_rx_busy      = state_q != IDLE;
  assign uart_rx_overrun   = overrun_q;
  assign uart_rx_frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table-driven bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_read = 1'b0;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid, uart_rx_busy, uart_rx_overrun, uart_rx_frame_err;
  int checks = 0;
  int errors = 0;
  int rises = 0;
  int busy_cnt = 0;
  logic valid_prev = 1'b0;
  uart_rx #(.BIT_RATE(1_000_000), .CLK_HZ(16_000_000), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .uart_rxd          (uart_rxd),
    .uart_rx_read      (uart_rx_read),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_valid     (uart_rx_valid),
    .uart_rx_busy      (uart_rx_busy),
    .uart_rx_overrun   (uart_rx_overrun),
    .uart_rx_frame_err (uart_rx_frame_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (uart_rx_valid && !valid_prev) rises++;
    if (uart_rx_busy) busy_cnt++;
    valid_prev <= uart_rx_valid;
  end
  typedef struct {
    logic [7:0] d;
    logic       stop;
    bit         rd;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_ovr;
    logic       e_ferr;
    int         e_rises;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit glitch, input int nbits);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++)
      for (int c = 0; c < 16; c++) begin
        uart_rxd = (glitch && c == 8) ? ~f[i] : f[i];
        @(negedge clk);
      end
  endtask
  task automatic do_read();
    uart_rx_read = 1'b1;
    @(negedge clk);
    uart_rx_read = 1'b0;
  endtask
  task automatic chk_all(input string tag, input logic [7:0] dat, input logic v, input logic o, input logic fe);
    chk({tag, "_data"}, 32'(uart_rx_data), 32'(dat));
    chk({tag, "_valid"}, 32'(uart_rx_valid), 32'(v));
    chk({tag, "_overrun"}, 32'(uart_rx_overrun), 32'(o));
    chk({tag, "_frame_err"}, 32'(uart_rx_frame_err), 32'(fe));
  endtask
  initial begin
    int r0, b0;
    bit timed_out;
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1};
    tbl[3] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1};
    tbl[4] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1};
    tbl[5] = '{8'hC3, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 0};
    tbl[6] = '{8'h81, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 0};
    tick(3);
    #1;
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset_busy", 32'(uart_rx_busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick(20);
    for (int i = 0; i < 7; i++) begin
      r0 = rises;
      send_frame(tbl[i].d, tbl[i].stop, 1'b0, 10);
      chk_all($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_valid, tbl[i].e_ovr, tbl[i].e_ferr);
      chk($sformatf("vec%0d_rises", i), 32'(rises - r0), 32'(tbl[i].e_rises));
      if (tbl[i].rd) begin
        do_read();
        chk_all($sformatf("vec%0d_read", i), tbl[i].e_data, 1'b0, 1'b0, 1'b0);
      end
    end
    uart_rxd = 1'b0;
    tick(320);
    chk("break_busy", 32'(uart_rx_busy), 32'd0);
    chk("break_valid", 32'(uart_rx_valid), 32'd0);
    chk("break_frame_err", 32'(uart_rx_frame_err), 32'd1);
    uart_rxd = 1'b1;
    tick(32);
    r0 = rises;
    send_frame(8'h42, 1'b1, 1'b0, 10);
    chk_all("after_break", 8'h42, 1'b1, 1'b0, 1'b1);
    chk("after_break_rises", 32'(rises - r0), 32'd1);
    do_read();
    chk_all("after_break_read", 8'h42, 1'b0, 1'b0, 1'b0);
    tick(16);
    b0 = busy_cnt;
    uart_rxd = 1'b0;
    tick(5);
    uart_rxd = 1'b1;
    tick(30);
    chk("glitch_busy_pulsed", 32'(busy_cnt > b0), 32'd1);
    chk("glitch_busy_now", 32'(uart_rx_busy), 32'd0);
    chk_all("glitch", 8'h42, 1'b0, 1'b0, 1'b0);
    send_frame(8'h24, 1'b1, 1'b0, 10);
    chk_all("pre_same_cycle", 8'h24, 1'b1, 1'b0, 1'b0);
    timed_out = 1'b0;
    fork
      send_frame(8'h99, 1'b1, 1'b0, 10);
      begin : watcher
        int n;
        n = 0;
        while (!uart_rx_busy && n < 100) begin @(negedge clk); n++; end
        while (uart_rx_busy && n < 300) begin @(negedge clk); n++; end
        if (n >= 100 && uart_rx_busy || n >= 300) timed_out = 1'b1;
        else begin
          uart_rx_read = 1'b1;
          @(negedge clk);
          uart_rx_read = 1'b0;
        end
      end
    join
    chk("same_cycle_timeout", 32'(timed_out), 32'd0);
    chk_all("same_cycle", 8'h99, 1'b1, 1'b0, 1'b0);
    do_read();
    chk("same_cycle_read_valid", 32'(uart_rx_valid), 32'd0);
    tick(16);
    send_frame(8'h77, 1'b1, 1'b0, 5);
    resetn = 1'b0;
    #1;
    chk_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mid_reset_busy", 32'(uart_rx_busy), 32'd0);
    tick(2);
    uart_rxd = 1'b1;
    resetn = 1'b1;
    tick(32);
    r0 = rises;
    send_frame(8'h11, 1'b1, 1'b0, 10);
    chk_all("post_reset", 8'h11, 1'b1, 1'b0, 1'b0);
    chk("post_reset_rises", 32'(rises - r0), 32'd1);
    do_read();
`ifdef UART_RX_MAJORITY_EN
    tick(16);
    send_frame(8'h96, 1'b1, 1'b1, 10);
    chk_all("majority", 8'h96, 1'b1, 1'b0, 1'b0);
    do_read();
`endif
    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
